// File: rtl/bram_stream_reader_pkg.sv
// Shared types and sizing constants for the BRAM stream reader.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = 2;
  // Wide enough for occupancy + in-flight read without overflow.
  localparam int CREDIT_W   = 3;

endpackage

// File: rtl/bram_stream_reader_skid_fifo.sv
// Two-entry output buffer holding {last, data}; head is zero when empty.
module stream_skid_fifo
  import bram_stream_pkg::*;
#(
  parameter int W = 73
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             head_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [W-1:0]     mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != OCC_W'(FIFO_DEPTH)) || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy  = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a (base, len) window of a 1-cycle-latency BRAM port as valid/ready words.
// Define BRAM_STREAM_WRAP_EN to wrap addresses modulo DEPTH instead of rejecting overruns.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int WIDTH     = 72,
  parameter int DEPTH     = 512,
  parameter int LOG_DEPTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LOG_DEPTH-1:0] cmd_base,
  input  logic [LOG_DEPTH:0]   cmd_len,
  output logic [LOG_DEPTH-1:0] bram_addr,
  output logic                 bram_en,
  input  logic [WIDTH-1:0]     bram_rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic                 done,
  output logic                 err
);

  localparam int LEN_W = LOG_DEPTH + 1;

  state_e               state_q, state_d;
  logic [LOG_DEPTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [LEN_W-1:0]     len_sat;
  logic                 cmd_fire, reject, pop, issue;
  logic [OCC_W-1:0]     occ;
  logic [CREDIT_W-1:0]  credit_used;
  logic [WIDTH:0]       head;
  logic                 head_valid;

  // Gated by done so the next command lands the cycle after the pulse.
  assign cmd_ready = (state_q == IDLE) && !done_q && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign len_sat   = (cmd_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cmd_len;

`ifdef BRAM_STREAM_WRAP_EN
  assign reject = 1'b0;
`else
  assign reject = (({1'b0, cmd_base} + len_sat) > LEN_W'(DEPTH));
`endif

  assign pop         = head_valid && m_ready;
  // A read issued now lands in the FIFO next cycle; it must fit even if nothing pops then.
  assign credit_used = CREDIT_W'(occ) + CREDIT_W'(inflight_q) - CREDIT_W'(pop);
  assign issue       = (state_q == RUN) && (credit_used < CREDIT_W'(FIFO_DEPTH));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == LEN_W'(1));
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if ((len_sat == '0) || reject) begin
            done_d = 1'b1;
            err_d  = reject;
          end else begin
            state_d = RUN;
            addr_d  = cmd_base;
            rem_d   = len_sat;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + LOG_DEPTH'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[WIDTH]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  stream_skid_fifo #(
    .W (WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  ({inflight_last_q, bram_rdata}),
    .pop        (pop),
    .head_data  (head),
    .head_valid (head_valid),
    .occupancy  (occ)
  );

  assign bram_en   = issue;
  assign bram_addr = addr_q;
  assign m_valid   = head_valid;
  assign m_data    = head[WIDTH-1:0];
  assign m_last    = head[WIDTH];
  assign done      = done_q;
  assign err       = err_q;

endmodule
